// File: rtl/sm4_pkg.sv
// SM4 constants, state encoding and word-level helpers shared by the iterative core
// and its round unit.
package sm4_pkg;

  typedef enum logic [2:0] {IDLE, KEXP, KREADY, RUN, DONE} sm4_state_e;

  localparam logic [31:0] FK [0:3] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

  localparam logic [31:0] CK [0:31] = '{
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269, 32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249, 32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229, 32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209, 32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279};

  localparam logic [7:0] SBOX [0:255] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48};

  function automatic logic [31:0] sbox32(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction

  function automatic logic [31:0] L_enc(input logic [31:0] b);
    return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
  endfunction

  function automatic logic [31:0] L_key(input logic [31:0] b);
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  // Byte 0 of a block is the MSB of word 0.
  function automatic logic [31:0] pack_word(input logic [7:0] b [0:15], input logic [1:0] w);
    return {b[{w, 2'd0}], b[{w, 2'd1}], b[{w, 2'd2}], b[{w, 2'd3}]};
  endfunction

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] i);
    logic [31:0] s;
    s = w << {i, 3'd0};
    return s[31:24];
  endfunction

endpackage

// File: rtl/sm4_round.sv
// One SM4 round: x4 = x0 ^ T(x1 ^ x2 ^ x3 ^ rk), combinational.
// sel_key_i picks the key-schedule linear transform (rk then carries CK[n]).
module sm4_round
  import sm4_pkg::*;
(
  input  logic [31:0] x0_i,
  input  logic [31:0] x1_i,
  input  logic [31:0] x2_i,
  input  logic [31:0] x3_i,
  input  logic [31:0] rk_i,
  input  logic        sel_key_i,
  output logic [31:0] x4_o
);

  logic [31:0] sb;

  assign sb   = sbox32(x1_i ^ x2_i ^ x3_i ^ rk_i);
  assign x4_o = x0_i ^ (sel_key_i ? L_key(sb) : L_enc(sb));

endmodule

// File: rtl/sm4_iter_core.sv
// Iterative SM4: key expansion and 32 cipher rounds share one chain of UNROLL round units;
// 32/UNROLL cycles per phase, result held in DONE until out_ready_i.
module sm4_iter_core
  import sm4_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key_i [0:15],
  input  logic       key_valid_i,
  output logic       key_ready_o,
  input  logic [7:0] src_i [0:15],
  input  logic       mode_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [7:0] dst_o [0:15],
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       key_loaded_o,
  output logic       busy_o
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
    $error("sm4_iter_core: UNROLL must be 1, 2, 4 or 8");
  end

  localparam logic [4:0] STEP = 5'(UNROLL);

  sm4_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] x_q [0:3];
  logic [31:0] rk_q [0:31];
  logic [31:0] dst_q [0:3];
  logic        mode_q, key_loaded_q;
  logic [31:0] w [0:UNROLL+3];
  logic        key_hs, blk_hs, last_rnd, in_kexp, in_run;

  assign in_kexp     = (state_q == KEXP);
  assign in_run      = (state_q == RUN);
  assign key_ready_o = (state_q == IDLE) || (state_q == KREADY);
  assign in_ready_o  = ((state_q == KREADY) && !key_valid_i) || ((state_q == DONE) && out_ready_i);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = in_kexp || in_run;
  assign key_loaded_o = key_loaded_q;
  assign key_hs      = key_valid_i && key_ready_o;
  assign blk_hs      = in_valid_i && in_ready_o;
  assign cnt_d       = cnt_q + STEP;
  assign last_rnd    = (cnt_d == 5'd0);

  for (genvar k = 0; k < 4; k++) begin : g_win
    assign w[k] = x_q[k];
  end

  // Decrypt walks the key file backwards: 31 - n is ~n in 5 bits.
  for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
    logic [4:0]  idx;
    logic [31:0] rnd_key;
    assign idx     = cnt_q + 5'(j);
    assign rnd_key = in_kexp ? CK[idx] : (mode_q ? rk_q[idx] : rk_q[~idx]);
    sm4_round u_round (
      .x0_i     (w[j]),
      .x1_i     (w[j+1]),
      .x2_i     (w[j+2]),
      .x3_i     (w[j+3]),
      .rk_i     (rnd_key),
      .sel_key_i(in_kexp),
      .x4_o     (w[j+4])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (key_hs) state_d = KEXP;
      KEXP:    if (last_rnd) state_d = KREADY;
      KREADY:  if (key_hs) state_d = KEXP;
               else if (blk_hs) state_d = RUN;
      RUN:     if (last_rnd) state_d = DONE;
      DONE:    if (out_ready_i) state_d = blk_hs ? RUN : KREADY;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      mode_q       <= 1'b0;
      key_loaded_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        x_q[i]   <= '0;
        dst_q[i] <= '0;
      end
      for (int i = 0; i < 32; i++) rk_q[i] <= '0;
    end else if (key_hs) begin
      cnt_q        <= '0;
      key_loaded_q <= 1'b0;
      for (int i = 0; i < 4; i++) x_q[i] <= pack_word(key_i, 2'(i)) ^ FK[i];
    end else if (blk_hs) begin
      cnt_q  <= '0;
      mode_q <= mode_i;
      for (int i = 0; i < 4; i++) x_q[i] <= pack_word(src_i, 2'(i));
    end else if (in_kexp || in_run) begin
      cnt_q <= cnt_d;
      for (int i = 0; i < 4; i++) x_q[i] <= w[UNROLL+i];
      if (in_kexp) begin
        for (int j = 0; j < UNROLL; j++) rk_q[cnt_q + 5'(j)] <= w[j+4];
        if (last_rnd) key_loaded_q <= 1'b1;
      end
      if (in_run && last_rnd) begin
        for (int i = 0; i < 4; i++) dst_q[i] <= w[UNROLL+3-i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) dst_o[i] = word_byte(dst_q[i/4], 2'(i % 4));
  end

endmodule

// File: tb/tb_sm4_iter_core.sv
// Bench for sm4_iter_core: four instances (UNROLL = 1, 2, 4, 8) checked against the
// standard SM4 vectors, plus handshake corner cases on the UNROLL=1 instance.
module tb_sm4_iter_core;

  localparam logic [127:0] STD_KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] STD_CT  = 128'h681edf34d206965e86b3e94f536e4246;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] key_s [0:15];
  logic [7:0] src_s [0:15];
  logic       mode_s;
  logic       key_valid_s [4];
  logic       in_valid_s  [4];
  logic       out_ready_s [4];
  logic       key_ready_w [4];
  logic       in_ready_w  [4];
  logic       out_valid_w [4];
  logic       key_loaded_w [4];
  logic       busy_w      [4];
  logic [127:0] dst_p [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [7:0] dst_l [0:15];
    sm4_iter_core #(.UNROLL(1 << g)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_i       (key_s),
      .key_valid_i (key_valid_s[g]),
      .key_ready_o (key_ready_w[g]),
      .src_i       (src_s),
      .mode_i      (mode_s),
      .in_valid_i  (in_valid_s[g]),
      .in_ready_o  (in_ready_w[g]),
      .dst_o       (dst_l),
      .out_valid_o (out_valid_w[g]),
      .out_ready_i (out_ready_s[g]),
      .key_loaded_o(key_loaded_w[g]),
      .busy_o      (busy_w[g])
    );
    assign dst_p[g] = {dst_l[0], dst_l[1], dst_l[2], dst_l[3], dst_l[4], dst_l[5], dst_l[6], dst_l[7],
                       dst_l[8], dst_l[9], dst_l[10], dst_l[11], dst_l[12], dst_l[13], dst_l[14], dst_l[15]};
  end

  typedef struct {
    logic [127:0] key;
    logic [127:0] src;
    logic         mode;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [2];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_key(input logic [127:0] k);
    for (int i = 0; i < 16; i++) key_s[i] = k[127-8*i -: 8];
  endtask

  task automatic set_src(input logic [127:0] s, input logic m);
    for (int i = 0; i < 16; i++) src_s[i] = s[127-8*i -: 8];
    mode_s = m;
  endtask

  task automatic do_key(input int d, input logic [127:0] k, output logic busy_after, output int lat);
    int n;
    set_key(k);
    key_valid_s[d] = 1'b1;
    n = 0;
    while (!key_ready_w[d] && n < 100) begin step(); n++; end
    step();
    key_valid_s[d] = 1'b0;
    busy_after = busy_w[d];
    lat = 0;
    while (!key_loaded_w[d] && lat < 100) begin step(); lat++; end
  endtask

  // Accepts one block, waits for its result and drains it with a one-cycle out_ready.
  task automatic do_block(input int d, input logic [127:0] s, input logic m,
                          output logic [127:0] res, output int lat);
    int n;
    set_src(s, m);
    in_valid_s[d] = 1'b1;
    n = 0;
    while (!in_ready_w[d] && n < 100) begin step(); n++; end
    step();
    in_valid_s[d] = 1'b0;
    lat = 0;
    while (!out_valid_w[d] && lat < 100) begin step(); lat++; end
    res = dst_p[d];
    out_ready_s[d] = 1'b1;
    step();
    out_ready_s[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res, ref_dst;
    logic         b, ok;
    int           lat, n;

    vecs[0] = '{key: STD_KEY, src: STD_KEY, mode: 1'b1, exp: STD_CT};
    vecs[1] = '{key: STD_KEY, src: STD_CT,  mode: 1'b0, exp: STD_KEY};

    rst_n = 1'b0;
    set_key('0);
    set_src('0, 1'b0);
    for (int d = 0; d < 4; d++) begin
      key_valid_s[d] = 1'b0;
      in_valid_s[d]  = 1'b0;
      out_ready_s[d] = 1'b0;
    end
    #23;
    rst_n = 1'b1;
    step();

    chk("reset key_ready",  128'(key_ready_w[0]),  128'd1);
    chk("reset key_loaded", 128'(key_loaded_w[0]), 128'd0);
    chk("reset out_valid",  128'(out_valid_w[0]),  128'd0);
    chk("reset busy",       128'(busy_w[0]),       128'd0);
    chk("reset in_ready",   128'(in_ready_w[0]),   128'd0);
    chk("reset dst",        dst_p[0],              128'd0);

    for (int d = 0; d < 4; d++) begin
      for (int v = 0; v < 2; v++) begin
        do_key(d, vecs[v].key, b, lat);
        chk($sformatf("u%0d v%0d kexp busy", 1 << d, v), 128'(b), 128'd1);
        chk($sformatf("u%0d v%0d key latency", 1 << d, v), 128'(lat), 128'(32 >> d));
        if (d == 0 && v == 0) begin
          chk("rk[0]",  128'(g_dut[0].u_dut.rk_q[0]),  128'hf12186f9);
          chk("rk[31]", 128'(g_dut[0].u_dut.rk_q[31]), 128'h9124a012);
        end
        do_block(d, vecs[v].src, vecs[v].mode, res, lat);
        chk($sformatf("u%0d v%0d dst", 1 << d, v), res, vecs[v].exp);
        chk($sformatf("u%0d v%0d block latency", 1 << d, v), 128'(lat), 128'(32 >> d));
        chk($sformatf("u%0d v%0d out_valid drop", 1 << d, v), 128'(out_valid_w[d]), 128'd0);
      end
    end

    // Backpressure in DONE, then back-to-back accept of a decrypt.
    set_src(STD_KEY, 1'b1);
    in_valid_s[0] = 1'b1;
    step();
    in_valid_s[0] = 1'b0;
    n = 0;
    while (!out_valid_w[0] && n < 100) begin step(); n++; end
    ref_dst = dst_p[0];
    chk("bp first dst", ref_dst, STD_CT);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (dst_p[0] !== ref_dst || out_valid_w[0] !== 1'b1 || in_ready_w[0] !== 1'b0) ok = 1'b0;
    end
    chk("bp hold stable", 128'(ok), 128'd1);
    set_src(STD_CT, 1'b0);
    in_valid_s[0]  = 1'b1;
    out_ready_s[0] = 1'b1;
    #1;
    chk("b2b in_ready", 128'(in_ready_w[0]), 128'd1);
    step();
    in_valid_s[0]  = 1'b0;
    out_ready_s[0] = 1'b0;
    chk("b2b out_valid drop", 128'(out_valid_w[0]), 128'd0);
    chk("b2b busy", 128'(busy_w[0]), 128'd1);
    lat = 0;
    while (!out_valid_w[0] && lat < 100) begin step(); lat++; end
    chk("b2b latency", 128'(lat), 128'd32);
    chk("b2b dst", dst_p[0], STD_KEY);
    out_ready_s[0] = 1'b1;
    step();
    out_ready_s[0] = 1'b0;

    // Key and block offered together in KREADY: the key wins.
    set_key(STD_KEY);
    set_src(STD_KEY, 1'b1);
    key_valid_s[0] = 1'b1;
    in_valid_s[0]  = 1'b1;
    #1;
    chk("contention in_ready", 128'(in_ready_w[0]), 128'd0);
    chk("contention key_ready", 128'(key_ready_w[0]), 128'd1);
    step();
    key_valid_s[0] = 1'b0;
    in_valid_s[0]  = 1'b0;
    chk("contention key_loaded cleared", 128'(key_loaded_w[0]), 128'd0);
    lat = 0;
    while (!key_loaded_w[0] && lat < 100) begin step(); lat++; end
    chk("contention rekey latency", 128'(lat), 128'd32);
    chk("contention block dropped", 128'(out_valid_w[0]), 128'd0);

    // A different key offered during RUN must be ignored.
    set_src(STD_KEY, 1'b1);
    in_valid_s[0] = 1'b1;
    step();
    in_valid_s[0] = 1'b0;
    set_key(128'h0);
    key_valid_s[0] = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (key_ready_w[0] !== 1'b0) ok = 1'b0;
      step();
    end
    key_valid_s[0] = 1'b0;
    chk("run key_ready low", 128'(ok), 128'd1);
    n = 0;
    while (!out_valid_w[0] && n < 100) begin step(); n++; end
    chk("run key ignored dst", dst_p[0], STD_CT);
    out_ready_s[0] = 1'b1;
    step();
    out_ready_s[0] = 1'b0;

    // Asynchronous reset while round 17 is executing.
    set_src(STD_CT, 1'b0);
    in_valid_s[0] = 1'b1;
    step();
    in_valid_s[0] = 1'b0;
    for (int i = 0; i < 17; i++) step();
    chk("pre-reset busy", 128'(busy_w[0]), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("rst out_valid",  128'(out_valid_w[0]),  128'd0);
    chk("rst dst",        dst_p[0],              128'd0);
    chk("rst key_loaded", 128'(key_loaded_w[0]), 128'd0);
    chk("rst key_ready",  128'(key_ready_w[0]),  128'd1);
    chk("rst busy",       128'(busy_w[0]),       128'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post-rst key_ready", 128'(key_ready_w[0]), 128'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
